hazard_ctrl: RTL and testbench

Hazard and forwarding controller for the 5-stage MIPS core. It drives the stall, flush and forward selects that the pipeline register/datapath block consumes. It keeps its own shadow copy of the E/M/W destination, write-enable and load state, so hazard detection is self-contained. It also tracks the multi-cycle HI/LO unit occupancy and stalls HI/LO readers and writers until the result is committed.

---
 rtl/hazard_ctrl.sv | 151 +++++++++++++++
 tb/tb_hazard_ctrl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl
// Brief    : Stall/flush/forward controller for the 5-stage MIPS pipeline,
//            with shadow E/M/W hazard state and HI/LO unit occupancy.
// Revision : 1.0
// ============================================================================
module hazard_ctrl #(
    parameter int MDU_LAT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] rs_d,
    input  logic [4:0] rt_d,
    input  logic       we_reg_d,
    input  logic [1:0] dm2reg_d,
    input  logic       branch_d,
    input  logic       jr_d,
    input  logic       hilo_we_d,
    input  logic       hilo_rd_d,
    input  logic [4:0] wa_e,
    output logic       stall_f,
    output logic       stall_d,
    output logic       flush_e,
    output logic       forward_ad,
    output logic       forward_bd,
    output logic [1:0] forward_ae,
    output logic [1:0] forward_be,
    output logic       mdu_busy
);

    localparam logic [3:0] C_MDU_LAT = 4'(MDU_LAT);
    localparam logic [1:0] C_DM_LOAD = 2'b01;
    localparam logic [1:0] C_FWD_RF  = 2'b00;
    localparam logic [1:0] C_FWD_WB  = 2'b01;
    localparam logic [1:0] C_FWD_MEM = 2'b10;

    logic [4:0] rs_e_q, rs_e_d;
    logic [4:0] rt_e_q, rt_e_d;
    logic       we_e_q, we_e_d;
    logic       load_e_q, load_e_d;
    logic [4:0] wa_m_q, wa_m_d;
    logic       we_m_q, we_m_d;
    logic       load_m_q, load_m_d;
    logic [4:0] wa_w_q, wa_w_d;
    logic       we_w_q, we_w_d;
    logic [3:0] mdu_cnt_q, mdu_cnt_d;

    logic w_e_hit_rs, w_e_hit_rt;
    logic w_m_ld_hit_rs, w_m_ld_hit_rt;
    logic w_lw_stall, w_br_stall, w_jr_stall, w_mdu_stall;
    logic w_stall;
    logic w_mdu_busy;

    // Execute operand select; register 0 is hard-wired and never forwarded.
    function automatic logic [1:0] fwd_e_sel(
        input logic [4:0] src,
        input logic       we_m,
        input logic [4:0] wa_m,
        input logic       we_w,
        input logic [4:0] wa_w
    );
        logic [1:0] sel;
        sel = C_FWD_RF;
        if (src != 5'd0 && we_m && src == wa_m) begin
            sel = C_FWD_MEM;
        end else if (src != 5'd0 && we_w && src == wa_w) begin
            sel = C_FWD_WB;
        end
        return sel;
    endfunction

    assign forward_ae = fwd_e_sel(rs_e_q, we_m_q, wa_m_q, we_w_q, wa_w_q);
    assign forward_be = fwd_e_sel(rt_e_q, we_m_q, wa_m_q, we_w_q, wa_w_q);
    assign forward_ad = (rs_d != 5'd0) && we_m_q && (rs_d == wa_m_q);
    assign forward_bd = (rt_d != 5'd0) && we_m_q && (rt_d == wa_m_q);

    assign w_e_hit_rs    = we_e_q && (wa_e != 5'd0) && (wa_e == rs_d);
    assign w_e_hit_rt    = we_e_q && (wa_e != 5'd0) && (wa_e == rt_d);
    assign w_m_ld_hit_rs = load_m_q && (wa_m_q != 5'd0) && (wa_m_q == rs_d);
    assign w_m_ld_hit_rt = load_m_q && (wa_m_q != 5'd0) && (wa_m_q == rt_d);

    assign w_lw_stall  = load_e_q && (w_e_hit_rs || w_e_hit_rt);
    assign w_br_stall  = branch_d && (w_e_hit_rs || w_e_hit_rt ||
                                      w_m_ld_hit_rs || w_m_ld_hit_rt);
    assign w_jr_stall  = jr_d && (w_e_hit_rs || w_m_ld_hit_rs);
    assign w_mdu_busy  = (mdu_cnt_q != 4'd0);
    assign w_mdu_stall = (hilo_rd_d || hilo_we_d) && w_mdu_busy;
    assign w_stall     = w_lw_stall || w_br_stall || w_jr_stall || w_mdu_stall;

    assign stall_f  = w_stall;
    assign stall_d  = w_stall;
    assign flush_e  = w_stall;
    assign mdu_busy = w_mdu_busy;

    always_comb begin
        rs_e_d    = rs_d;
        rt_e_d    = rt_d;
        we_e_d    = we_reg_d;
        load_e_d  = (dm2reg_d == C_DM_LOAD);
        wa_m_d    = wa_e;
        we_m_d    = we_e_q;
        load_m_d  = load_e_q;
        wa_w_d    = wa_m_q;
        we_w_d    = we_m_q;
        mdu_cnt_d = mdu_cnt_q;

        // The flushed slot becomes a bubble so no stale load or forward survives.
        if (w_stall) begin
            rs_e_d   = 5'd0;
            rt_e_d   = 5'd0;
            we_e_d   = 1'b0;
            load_e_d = 1'b0;
        end

        // A HI/LO writer starts the count only on the edge it leaves decode.
        if (hilo_we_d && !w_stall) begin
            mdu_cnt_d = C_MDU_LAT;
        end else if (w_mdu_busy) begin
            mdu_cnt_d = mdu_cnt_q - 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rs_e_q    <= 5'd0;
            rt_e_q    <= 5'd0;
            we_e_q    <= 1'b0;
            load_e_q  <= 1'b0;
            wa_m_q    <= 5'd0;
            we_m_q    <= 1'b0;
            load_m_q  <= 1'b0;
            wa_w_q    <= 5'd0;
            we_w_q    <= 1'b0;
            mdu_cnt_q <= 4'd0;
        end else begin
            rs_e_q    <= rs_e_d;
            rt_e_q    <= rt_e_d;
            we_e_q    <= we_e_d;
            load_e_q  <= load_e_d;
            wa_m_q    <= wa_m_d;
            we_m_q    <= we_m_d;
            load_m_q  <= load_m_d;
            wa_w_q    <= wa_w_d;
            we_w_q    <= we_w_d;
            mdu_cnt_q <= mdu_cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_ctrl
// Brief    : Self-checking bench: scripted vectors, multi-cycle corner cases
//            and a random instruction stream against a pipeline-slot model.
// Revision : 1.0
// ============================================================================
module tb_hazard_ctrl;

    localparam int C_LAT = 4;

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] dst;
        logic       we;
        logic [1:0] dm;
        logic       br;
        logic       jr;
        logic       hwe;
        logic       hrd;
    } ins_t;

    typedef struct {
        ins_t       ins;
        logic [4:0] wa;
        logic [9:0] exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] rs_d = '0, rt_d = '0, wa_e = '0;
    logic       we_reg_d = 1'b0, branch_d = 1'b0, jr_d = 1'b0;
    logic       hilo_we_d = 1'b0, hilo_rd_d = 1'b0;
    logic [1:0] dm2reg_d = '0;
    logic       stall_f, stall_d, flush_e, forward_ad, forward_bd, mdu_busy;
    logic [1:0] forward_ae, forward_be;
    logic [9:0] w_obs;

    int n_cmp = 0;
    int n_bad = 0;

    hazard_ctrl #(.MDU_LAT(C_LAT)) u_dut (
        .clk(clk), .rst(rst), .rs_d(rs_d), .rt_d(rt_d), .we_reg_d(we_reg_d),
        .dm2reg_d(dm2reg_d), .branch_d(branch_d), .jr_d(jr_d),
        .hilo_we_d(hilo_we_d), .hilo_rd_d(hilo_rd_d), .wa_e(wa_e),
        .stall_f(stall_f), .stall_d(stall_d), .flush_e(flush_e),
        .forward_ad(forward_ad), .forward_bd(forward_bd),
        .forward_ae(forward_ae), .forward_be(forward_be), .mdu_busy(mdu_busy)
    );

    always #5 clk = ~clk;

    assign w_obs = {stall_f, stall_d, flush_e, forward_ad, forward_bd,
                    forward_ae, forward_be, mdu_busy};

    function automatic ins_t mk(input logic [4:0] rs, rt, dst, input logic we,
                                input logic [1:0] dm, input logic br, jr, hwe, hrd);
        ins_t i;
        i = '{rs: rs, rt: rt, dst: dst, we: we, dm: dm, br: br, jr: jr, hwe: hwe, hrd: hrd};
        return i;
    endfunction

    function automatic ins_t alu(input logic [4:0] rs, rt, dst);
        return mk(rs, rt, dst, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    endfunction
    function automatic ins_t ld(input logic [4:0] rt);
        return mk(5'd0, rt, rt, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
    endfunction
    function automatic ins_t beq(input logic [4:0] rs, rt);
        return mk(rs, rt, 5'd0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    endfunction
    function automatic ins_t mult(input logic [4:0] rs, rt);
        return mk(rs, rt, 5'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
    endfunction
    function automatic ins_t mfhi(input logic [4:0] dst);
        return mk(5'd0, 5'd0, dst, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
    endfunction

    function automatic logic [9:0] ex(input logic st, fad, fbd, input logic [1:0] fae, fbe,
                                      input logic busy);
        return {st, st, st, fad, fbd, fae, fbe, busy};
    endfunction

    function automatic vec_t mkv(input ins_t i, input logic [4:0] wa, input logic [9:0] e);
        vec_t v;
        v.ins = i;
        v.wa  = wa;
        v.exp = e;
        return v;
    endfunction

    // Reference model: a slot holds the instruction occupying a stage.
    function automatic bit writes(input ins_t s, input logic [4:0] r);
        return s.we && r != 5'd0 && s.dst == r;
    endfunction
    function automatic bit is_load(input ins_t s);
        return s.dm == 2'b01;
    endfunction
    function automatic bit br_hit(input ins_t e, m, input logic [4:0] r);
        return writes(e, r) || (is_load(m) && r != 5'd0 && m.dst == r);
    endfunction
    function automatic logic [1:0] fwd(input ins_t m, w, input logic [4:0] r);
        if (writes(m, r)) return 2'b10;
        if (writes(w, r)) return 2'b01;
        return 2'b00;
    endfunction
    function automatic logic [9:0] model(input ins_t d, e, m, w, input int rem);
        bit st;
        st = (is_load(e) && (writes(e, d.rs) || writes(e, d.rt)))
          || (d.br && (br_hit(e, m, d.rs) || br_hit(e, m, d.rt)))
          || (d.jr && br_hit(e, m, d.rs))
          || ((d.hwe || d.hrd) && rem > 0);
        return ex(st, writes(m, d.rs), writes(m, d.rt), fwd(m, w, e.rs), fwd(m, w, e.rt),
                  rem > 0);
    endfunction

    function automatic ins_t rand_ins();
        ins_t i;
        i.rs  = 5'($urandom_range(0, 3));
        i.rt  = 5'($urandom_range(0, 3));
        i.dst = 5'($urandom_range(0, 3));
        i.we  = ($urandom_range(0, 3) != 0);
        i.dm  = 2'($urandom_range(0, 3));
        i.br  = ($urandom_range(0, 5) == 0);
        i.jr  = ($urandom_range(0, 7) == 0);
        i.hwe = ($urandom_range(0, 9) == 0);
        i.hrd = ($urandom_range(0, 9) == 0);
        return i;
    endfunction

    task automatic apply(input ins_t i, input logic [4:0] wa);
        rs_d      = i.rs;
        rt_d      = i.rt;
        we_reg_d  = i.we;
        dm2reg_d  = i.dm;
        branch_d  = i.br;
        jr_d      = i.jr;
        hilo_we_d = i.hwe;
        hilo_rd_d = i.hrd;
        wa_e      = wa;
    endtask

    task automatic check(input string name, input int idx, input logic [9:0] e);
        n_cmp++;
        if (w_obs !== e) begin
            n_bad++;
            $display("FAIL %s step %0d: got %b required %b", name, idx, w_obs, e);
        end
    endtask

    // Apply one cycle of inputs, compare mid-cycle, then advance past the edge.
    task automatic step(input string name, input int idx, input ins_t i,
                        input logic [4:0] wa, input logic [9:0] e);
        apply(i, wa);
        #3;
        check(name, idx, e);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        apply('0, 5'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    vec_t tbl[17];

    initial begin
        tbl[0]  = mkv(alu(1, 2, 3), 5'd0, ex(0, 0, 0, 2'd0, 2'd0, 0));
        tbl[1]  = mkv(alu(3, 5, 4), 5'd3, ex(0, 0, 0, 2'd0, 2'd0, 0));
        tbl[2]  = mkv('0,           5'd4, ex(0, 0, 0, 2'd2, 2'd0, 0));
        tbl[3]  = mkv(alu(4, 4, 6), 5'd0, ex(0, 1, 1, 2'd0, 2'd0, 0));
        tbl[4]  = mkv(ld(2),        5'd6, ex(0, 0, 0, 2'd1, 2'd1, 0));
        tbl[5]  = mkv(alu(2, 7, 6), 5'd2, ex(1, 0, 0, 2'd0, 2'd0, 0));
        tbl[6]  = mkv(alu(2, 7, 6), 5'd0, ex(0, 1, 0, 2'd0, 2'd0, 0));
        tbl[7]  = mkv(ld(0),        5'd6, ex(0, 0, 0, 2'd1, 2'd0, 0));
        tbl[8]  = mkv(alu(0, 1, 9), 5'd0, ex(0, 0, 0, 2'd0, 2'd0, 0));
        tbl[9]  = mkv(alu(1, 1, 8), 5'd9, ex(0, 0, 0, 2'd0, 2'd0, 0));
        tbl[10] = mkv(beq(8, 9),    5'd8, ex(1, 0, 1, 2'd0, 2'd0, 0));
        tbl[11] = mkv(beq(8, 9),    5'd0, ex(0, 1, 0, 2'd0, 2'd0, 0));
        tbl[12] = mkv(ld(8),        5'd0, ex(0, 0, 0, 2'd1, 2'd0, 0));
        tbl[13] = mkv(beq(8, 9),    5'd8, ex(1, 0, 0, 2'd0, 2'd0, 0));
        tbl[14] = mkv(beq(8, 9),    5'd0, ex(1, 1, 0, 2'd0, 2'd0, 0));
        tbl[15] = mkv(beq(8, 9),    5'd0, ex(0, 0, 0, 2'd0, 2'd0, 0));
        tbl[16] = mkv('0,           5'd0, ex(0, 0, 0, 2'd0, 2'd0, 0));

        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int k = 0; k < 17; k++) begin
            step("table", k, tbl[k].ins, tbl[k].wa, tbl[k].exp);
        end

        // mult immediately followed by mfhi stalls for exactly MDU_LAT cycles.
        do_reset();
        step("mdu_start", 0, mult(1, 2), 5'd0, ex(0, 0, 0, 2'd0, 2'd0, 0));
        for (int k = 1; k <= C_LAT; k++) begin
            step("mdu_stall", k, mfhi(5), 5'd0, ex(1, 0, 0, 2'd0, 2'd0, 1));
        end
        step("mdu_done", 0, mfhi(5), 5'd0, ex(0, 0, 0, 2'd0, 2'd0, 0));

        // mult held behind a load-use stall does not start counting early.
        do_reset();
        step("held_mult", 0, ld(2),      5'd0, ex(0, 0, 0, 2'd0, 2'd0, 0));
        step("held_mult", 1, mult(2, 3), 5'd2, ex(1, 0, 0, 2'd0, 2'd0, 0));
        step("held_mult", 2, mult(2, 3), 5'd0, ex(0, 1, 0, 2'd0, 2'd0, 0));
        step("held_mult", 3, '0,         5'd0, ex(0, 0, 0, 2'd1, 2'd0, 1));
        step("held_mult", 4, '0,         5'd0, ex(0, 0, 0, 2'd0, 2'd0, 1));

        // Reset asserted mid-count clears busy and stall in the same cycle.
        do_reset();
        step("rst_mid", 0, mult(1, 2),   5'd0, ex(0, 0, 0, 2'd0, 2'd0, 0));
        step("rst_mid", 1, alu(1, 2, 3), 5'd0, ex(0, 0, 0, 2'd0, 2'd0, 1));
        apply(mfhi(5), 5'd3);
        #3;
        check("rst_mid", 2, ex(1, 0, 0, 2'd0, 2'd0, 1));
        rst = 1'b1;
        #1;
        check("rst_async", 0, ex(0, 0, 0, 2'd0, 2'd0, 0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        step("rst_after", 0, '0, 5'd0, ex(0, 0, 0, 2'd0, 2'd0, 0));
        step("rst_after", 1, '0, 5'd0, ex(0, 0, 0, 2'd0, 2'd0, 0));

        // Random instruction stream against the slot model.
        do_reset();
        begin
            ins_t d, e, m, w, bub;
            int   rem;
            bit   r, st;
            logic [9:0] exp_v;
            e = '0; m = '0; w = '0; rem = 0;
            d = rand_ins();
            for (int cyc = 0; cyc < 10000; cyc++) begin
                r = ($urandom_range(0, 299) == 0);
                if (r) begin
                    e = '0; m = '0; w = '0; rem = 0;
                end
                apply(d, e.dst);
                rst = r;
                #3;
                exp_v = model(d, e, m, w, rem);
                check("random", cyc, exp_v);
                st = exp_v[9];
                if (!r) begin
                    if (d.hwe && !st) rem = C_LAT;
                    else if (rem > 0) rem = rem - 1;
                    w = m;
                    m = e;
                    if (st) begin
                        bub = '0;
                        bub.dst = 5'($urandom_range(0, 3));
                        e = bub;
                    end else begin
                        e = d;
                    end
                end
                if (r || !st) d = rand_ins();
                @(posedge clk);
                #1;
                rst = 1'b0;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
